// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
//   Shared definitions for the data-memory arbiter slice:
//     - default core count and bus widths
//     - arbiter FSM state encoding
//     - wrap_add: modular index helper used for round-robin scans and the
//       pointer update
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

  localparam int NCORE_DEFAULT  = 8;
  localparam int WIDTH_DEFAULT  = 8;
  localparam int ADDR_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } arb_state_e;

  // (base + off) mod n, valid for base < n and off < n
  function automatic int wrap_add(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    return (sum >= n) ? sum - n : sum;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_rr_pick
//   Combinational round-robin priority encoder. Returns the first asserted
//   request found when scanning ptr, ptr+1, ..., NCORE-1, 0, ..., ptr-1.
// Ports
//   req  in   NCORE   request vector (already qualified by the caller)
//   ptr  in   PTR_W   index with highest priority this cycle
//   any  out  1       at least one request present
//   idx  out  PTR_W   winning index (0 when no request)
// -----------------------------------------------------------------------------
module dmem_arbiter_rr_pick
  import dmem_arbiter_pkg::*;
#(
  parameter int NCORE = NCORE_DEFAULT,
  parameter int PTR_W = $clog2(NCORE)
) (
  input  logic [NCORE-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic             any,
  output logic [PTR_W-1:0] idx
);

  logic [PTR_W-1:0] cand;

  // Scan from the farthest offset back to offset 0 so that the candidate
  // closest to ptr is the last one written and therefore wins.
  always_comb begin
    any  = |req;
    idx  = '0;
    cand = '0;
    for (int off = NCORE - 1; off >= 0; off--) begin
      cand = PTR_W'(wrap_add(int'(ptr), off, NCORE));
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Serialises independent load/store requests from NCORE cores onto a single
//   port data RAM with round-robin fairness. One access every three cycles at
//   most: IDLE (grant, drive RAM) -> ACCESS (capture, strobe) -> DONE (gap
//   while the served core drops its request) -> IDLE. All state changes on
//   the falling edge of Clk; Rst is asynchronous and active high.
// Ports
//   Clk, Rst    clock (negedge active) and async reset
//   dREAD       per-core load request, held until that core's dmemAV
//   dWRITE      per-core store request, held until that core's dmemAV
//   coreS       per-core finished/disabled flag; requests ignored when 1
//   ADDR_IN     per-core address, core k at [k*ADDR_W +: ADDR_W]
//   WDATA_IN    per-core store data, core k at [k*WIDTH +: WIDTH]
//   MEM_RDATA   RAM read data, valid one negedge after mem_rEN
//   mem_rEN     RAM read enable (one cycle)
//   mem_wEN     RAM write enable (one cycle)
//   MEM_ADDR    RAM address, holds when idle
//   MEM_WDATA   RAM write data, holds when idle
//   DATA_OUT    per-core load result, core k at [k*WIDTH +: WIDTH]
//   dmemAV      per-core one-cycle completion strobe (one-hot)
//   busy        high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int NCORE  = NCORE_DEFAULT,
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [NCORE-1:0]        dREAD,
  input  logic [NCORE-1:0]        dWRITE,
  input  logic [NCORE-1:0]        coreS,
  input  logic [NCORE*ADDR_W-1:0] ADDR_IN,
  input  logic [NCORE*WIDTH-1:0]  WDATA_IN,
  input  logic [WIDTH-1:0]        MEM_RDATA,
  output logic                    mem_rEN,
  output logic                    mem_wEN,
  output logic [ADDR_W-1:0]       MEM_ADDR,
  output logic [WIDTH-1:0]        MEM_WDATA,
  output logic [NCORE*WIDTH-1:0]  DATA_OUT,
  output logic [NCORE-1:0]        dmemAV,
  output logic                    busy
);

  localparam int PTR_W = $clog2(NCORE);

  arb_state_e       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gnt_q, gnt_d;
  logic             is_store_q, is_store_d;
  logic             mem_ren_q, mem_ren_d;
  logic             mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [WIDTH-1:0] data_out_q [NCORE];
  logic [WIDTH-1:0] data_out_d [NCORE];
  logic [NCORE-1:0] dmem_av_q, dmem_av_d;

  logic [NCORE-1:0] eligible;
  logic             pick_any;
  logic [PTR_W-1:0] pick_idx;

  logic [ADDR_W-1:0] addr_arr  [NCORE];
  logic [WIDTH-1:0]  wdata_arr [NCORE];

  // Unpack the flat per-core buses into arrays and repack the results.
  for (genvar k = 0; k < NCORE; k++) begin : g_core
    assign addr_arr[k]                  = ADDR_IN[k*ADDR_W +: ADDR_W];
    assign wdata_arr[k]                 = WDATA_IN[k*WIDTH +: WIDTH];
    assign DATA_OUT[k*WIDTH +: WIDTH]   = data_out_q[k];
  end

  assign eligible = (dREAD | dWRITE) & ~coreS;

  dmem_arbiter_rr_pick #(
    .NCORE (NCORE),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req (eligible),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Next-state and RAM-side outputs. Enables default low so they are only
  // ever high for the single cycle following a grant.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    is_store_d  = is_store_q;
    mem_ren_d   = 1'b0;
    mem_wen_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    data_out_d  = data_out_q;
    dmem_av_d   = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d      = pick_idx;
          mem_addr_d = addr_arr[pick_idx];
          // A core asserting both load and store is treated as a store.
          is_store_d = dWRITE[pick_idx];
          if (dWRITE[pick_idx]) begin
            mem_wen_d   = 1'b1;
            mem_wdata_d = wdata_arr[pick_idx];
          end else begin
            mem_ren_d = 1'b1;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!is_store_q) begin
          data_out_d[gnt_q] = MEM_RDATA;
        end
        dmem_av_d[gnt_q] = 1'b1;
        // Priority moves to the core after the one just served.
        ptr_d   = PTR_W'(wrap_add(int'(gnt_q), 1, NCORE));
        state_d = DONE;
      end
      DONE: begin
        // No arbitration here: the served core is still seen requesting
        // until it observes dmemAV and drops its request.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, updated on the falling edge.
  always_ff @(negedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      is_store_q  <= 1'b0;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      dmem_av_q   <= '0;
      for (int k = 0; k < NCORE; k++) begin
        data_out_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      is_store_q  <= is_store_d;
      mem_ren_q   <= mem_ren_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      dmem_av_q   <= dmem_av_d;
      data_out_q  <= data_out_d;
    end
  end

  assign mem_rEN   = mem_ren_q;
  assign mem_wEN   = mem_wen_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign dmemAV    = dmem_av_q;
  assign busy      = (state_q != IDLE);

endmodule
